// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader: FSM states
// and the byte-stream geometry of a program image.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_LEN0,
    ST_LEN1,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam int LANES  = 4;
  localparam int LANE_W = $clog2(LANES);
  localparam int CSUM_W = 8;

  // States in which the loader is still consuming image bytes.
  function automatic logic is_receiving(input state_e s);
    return s inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM};
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-serial valid/ready stream feeding the boot loader.
interface imem_boot_loader_if;

  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;

  modport master (
    output rx_valid,
    output rx_data,
    input  rx_ready
  );

  modport slave (
    input  rx_valid,
    input  rx_data,
    output rx_ready
  );

endinterface

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler: the first byte of a word lands in
// bits [7:0]; the fourth byte completes the word combinationally.
module word_assembler
  import boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_out,
  output logic        word_done
);

  localparam int SH_W = 8 * (LANES - 1);

  logic [LANE_W-1:0] lane_q, lane_d;
  logic [SH_W-1:0]   shreg_q, shreg_d;

  // Only the first three lanes need storage; the last byte is taken straight
  // from the input so the word is available on the cycle it completes.
  assign word_out  = {byte_in, shreg_q};
  assign word_done = byte_vld && !clear && (lane_q == LANE_W'(LANES - 1));

  // NOTE: every always_comb target gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    lane_d  = lane_q;
    shreg_d = shreg_q;
    if (clear) begin
      lane_d  = '0;
      shreg_d = '0;
    end else if (byte_vld) begin
      lane_d  = lane_q + 1'b1;
      shreg_d = {byte_in, shreg_q[SH_W-1:8]};
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge value of every other flop regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q  <= '0;
      shreg_q <= '0;
    end else begin
      lane_q  <= lane_d;
      shreg_q <= shreg_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Receives a length-prefixed, XOR-checksummed program image and writes it
// into instruction memory, holding the core in reset until it verifies.
module imem_boot_loader
  import boot_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   rx,
  output logic                imem_we,
  output logic [ADDR_W-1:0]   imem_addr,
  output logic [31:0]         imem_wd,
  output logic                core_reset,
  output logic                done,
  output logic                error
);

  state_e              state_q, state_d;
  logic [15:0]         len_q, len_d;
  logic [ADDR_W:0]     word_cnt_q, word_cnt_d;
  logic [CSUM_W-1:0]   csum_q, csum_d;
  logic                rx_ready_q, rx_ready_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [31:0]         imem_wd_q, imem_wd_d;
  logic                core_reset_q, core_reset_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                data_stb;
  logic [15:0]         len_full;
  logic [ADDR_W:0]     word_cnt_inc;
  logic [31:0]         asm_word;
  logic                asm_done;

  assign accept       = rx.rx_valid & rx_ready_q;
  assign data_stb     = accept && (state_q == ST_DATA);
  assign len_full     = {rx.rx_data, len_q[7:0]};
  assign word_cnt_inc = word_cnt_q + 1'b1;

  word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (state_q == ST_LEN0),
    .byte_vld  (data_stb),
    .byte_in   (rx.rx_data),
    .word_out  (asm_word),
    .word_done (asm_done)
  );

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    word_cnt_d  = word_cnt_q;
    csum_d      = csum_q;
    imem_we_d   = 1'b0;
    imem_addr_d = imem_addr_q;
    imem_wd_d   = imem_wd_q;

    case (state_q)
      ST_LEN0: begin
        word_cnt_d = '0;
        csum_d     = '0;
        if (accept) begin
          len_d   = {8'h00, rx.rx_data};
          state_d = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (accept) begin
          len_d = len_full;
          // Full 16-bit compare: an oversize length must never alias into range.
          if (len_full > 16'(DEPTH))  state_d = ST_ERR;
          else if (len_full == 16'd0) state_d = ST_CSUM;
          else                        state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (data_stb) csum_d = csum_q ^ rx.rx_data;
        if (asm_done) begin
          imem_we_d   = 1'b1;
          imem_addr_d = word_cnt_q[ADDR_W-1:0];
          imem_wd_d   = asm_word;
          word_cnt_d  = word_cnt_inc;
          if (16'(word_cnt_inc) == len_q) state_d = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (accept) state_d = (rx.rx_data == csum_q) ? ST_DONE : ST_ERR;
      end
      ST_DONE, ST_ERR: ;
      default: state_d = ST_LEN0;
    endcase
  end

  // Status outputs follow the next state so they change on the same edge
  // that accepts the deciding byte.
  always_comb begin
    rx_ready_d   = is_receiving(state_d);
    core_reset_d = (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LEN0;
      len_q        <= '0;
      word_cnt_q   <= '0;
      csum_q       <= '0;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wd_q    <= '0;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      word_cnt_q   <= word_cnt_d;
      csum_q       <= csum_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wd_q    <= imem_wd_d;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign rx.rx_ready = rx_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wd     = imem_wd_q;
  assign core_reset  = core_reset_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: inputs change on the falling edge,
// outputs are sampled on the falling edge, writes are logged by a monitor.
module tb_imem_boot_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wd;
  logic              core_reset;
  logic              done;
  logic              error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [31:0]       wr_data[$];
  logic [31:0]       img[DEPTH];

  always #5 clk = ~clk;

  imem_boot_loader_if rx_if ();

  imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx_if.slave),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wd    (imem_wd),
    .core_reset (core_reset),
    .done       (done),
    .error      (error)
  );

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      wr_addr.push_back(imem_addr);
      wr_data.push_back(imem_wd);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_if.rx_valid = 1'b1;
    rx_if.rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_if.rx_valid = 1'b0;
      rx_if.rx_data  = 8'($urandom);
    end
  endtask

  task automatic do_reset();
    rx_if.rx_valid = 1'b0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic send_image(input logic [15:0] len, input int nwords,
                            input logic [7:0] csum_flip, input bit gaps);
    logic [7:0] csum;
    csum = 8'h00;
    for (int i = 0; i < nwords; i++)
      for (int k = 0; k < 4; k++) csum ^= img[i][8*k +: 8];
    send_byte(len[7:0]);
    send_byte(len[15:8]);
    for (int i = 0; i < nwords; i++) begin
      for (int k = 0; k < 4; k++) begin
        if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
        send_byte(img[i][8*k +: 8]);
      end
    end
    send_byte(csum ^ csum_flip);
    idle(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx_if.rx_valid = 1'b0;
    rx_if.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    n_cmp++; if (rx_if.rx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_rx_ready: got %b want 1", rx_if.rx_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL reset_imem_we: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== '0) begin n_bad++; $display("FAIL reset_imem_addr: got %0d want 0", imem_addr); end
    n_cmp++; if (imem_wd !== 32'h0) begin n_bad++; $display("FAIL reset_imem_wd: got %h want 0", imem_wd); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL reset_core_reset: got %b want 1", core_reset); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL reset_error: got %b want 0", error); end
    reset = 1'b0;
  endtask

  // Two words E3A00005 and E2801001; their byte XOR is 0x35.
  task automatic test_basic();
    do_reset();
    send_byte(8'h02); send_byte(8'h00);
    send_byte(8'h05); send_byte(8'h00); send_byte(8'hA0); send_byte(8'hE3);
    send_byte(8'h01);
    n_cmp++; if (imem_we !== 1'b1) begin n_bad++; $display("FAIL basic_we0: got %b want 1", imem_we); end
    n_cmp++; if (imem_addr !== 6'd0) begin n_bad++; $display("FAIL basic_addr0: got %0d want 0", imem_addr); end
    n_cmp++; if (imem_wd !== 32'hE3A00005) begin n_bad++; $display("FAIL basic_wd0: got %h want e3a00005", imem_wd); end
    send_byte(8'h10); send_byte(8'h80); send_byte(8'hE2);
    send_byte(8'h35);
    n_cmp++; if (imem_we !== 1'b1) begin n_bad++; $display("FAIL basic_we1: got %b want 1", imem_we); end
    n_cmp++; if (imem_addr !== 6'd1) begin n_bad++; $display("FAIL basic_addr1: got %0d want 1", imem_addr); end
    n_cmp++; if (imem_wd !== 32'hE2801001) begin n_bad++; $display("FAIL basic_wd1: got %h want e2801001", imem_wd); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL basic_core_reset_early: got %b want 1", core_reset); end
    idle(1);
    n_cmp++; if (core_reset !== 1'b0) begin n_bad++; $display("FAIL basic_core_reset: got %b want 0", core_reset); end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL basic_done: got %b want 1", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL basic_error: got %b want 0", error); end
    n_cmp++; if (rx_if.rx_ready !== 1'b0) begin n_bad++; $display("FAIL basic_rx_ready: got %b want 0", rx_if.rx_ready); end
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL basic_we_after: got %b want 0", imem_we); end
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL basic_write_count: got %0d want 2", wr_addr.size()); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    img[0] = 32'hE3A00005;
    img[1] = 32'hE2801001;
    send_image(16'd2, 2, 8'h01, 1'b0);
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL badcs_write_count: got %0d want 2", wr_addr.size()); end
    if (wr_addr.size() == 2) begin
      n_cmp++; if (wr_data[1] !== 32'hE2801001 || wr_addr[1] !== 6'd1) begin n_bad++; $display("FAIL badcs_last_write: got %0d:%h want 1:e2801001", wr_addr[1], wr_data[1]); end
    end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL badcs_error: got %b want 1", error); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL badcs_done: got %b want 0", done); end
    n_cmp++; if (core_reset !== 1'b1) begin n_bad++; $display("FAIL badcs_core_reset: got %b want 1", core_reset); end
    send_byte(8'h00); send_byte(8'h00); send_byte(8'hFF); send_byte(8'hFF);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    n_cmp++; if (rx_if.rx_ready !== 1'b0) begin n_bad++; $display("FAIL badcs_rx_ready: got %b want 0", rx_if.rx_ready); end
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL badcs_error_sticky: got %b want 1", error); end
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL badcs_no_more_writes: got %0d want 2", wr_addr.size()); end
  endtask

  task automatic test_len_overflow();
    do_reset();
    send_byte(8'h41); send_byte(8'h00);
    idle(1);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL ovf_error: got %b want 1", error); end
    n_cmp++; if (rx_if.rx_ready !== 1'b0) begin n_bad++; $display("FAIL ovf_rx_ready: got %b want 0", rx_if.rx_ready); end
    for (int i = 0; i < 12; i++) send_byte(8'(i * 17));
    idle(2);
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL ovf_writes: got %0d want 0", wr_addr.size()); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL ovf_done: got %b want 0", done); end
  endtask

  task automatic test_len_zero();
    do_reset();
    send_image(16'd0, 0, 8'h00, 1'b0);
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b want 1", done); end
    n_cmp++; if (core_reset !== 1'b0) begin n_bad++; $display("FAIL zero_core_reset: got %b want 0", core_reset); end
    n_cmp++; if (wr_addr.size() != 0) begin n_bad++; $display("FAIL zero_writes: got %0d want 0", wr_addr.size()); end
    do_reset();
    send_image(16'd0, 0, 8'h5A, 1'b0);
    n_cmp++; if (error !== 1'b1) begin n_bad++; $display("FAIL zero_bad_error: got %b want 1", error); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_bad_done: got %b want 0", done); end
  endtask

  task automatic test_full_depth();
    do_reset();
    for (int i = 0; i < DEPTH; i++) img[i] = $urandom;
    send_image(16'(DEPTH), DEPTH, 8'h00, 1'b1);
    n_cmp++; if (wr_addr.size() != DEPTH) begin n_bad++; $display("FAIL full_write_count: got %0d want %0d", wr_addr.size(), DEPTH); end
    for (int i = 0; i < wr_addr.size() && i < DEPTH; i++) begin
      n_cmp++; if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== img[i]) begin
        n_bad++; $display("FAIL full_write_%0d: got %0d:%h want %0d:%h", i, wr_addr[i], wr_data[i], i, img[i]);
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL full_done: got %b want 1", done); end
    n_cmp++; if (error !== 1'b0) begin n_bad++; $display("FAIL full_error: got %b want 0", error); end
  endtask

  task automatic test_reset_mid_load();
    do_reset();
    img[0] = 32'hA1B2C3D4;
    img[1] = 32'h0BADF00D;
    img[2] = 32'hCAFEBABE;
    send_byte(8'h03); send_byte(8'h00);
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8]);
    send_byte(img[2][7:0]);
    n_cmp++; if (imem_we !== 1'b1) begin n_bad++; $display("FAIL mid_pending_we: got %b want 1", imem_we); end
    #1 reset = 1'b1;
    #1;
    n_cmp++; if (imem_we !== 1'b0) begin n_bad++; $display("FAIL mid_we_dropped: got %b want 0", imem_we); end
    n_cmp++; if (imem_addr !== '0 || imem_wd !== 32'h0) begin n_bad++; $display("FAIL mid_bus_cleared: got %0d:%h want 0:0", imem_addr, imem_wd); end
    n_cmp++; if (rx_if.rx_ready !== 1'b1 || core_reset !== 1'b1) begin n_bad++; $display("FAIL mid_ready_core: got %b%b want 11", rx_if.rx_ready, core_reset); end
    n_cmp++; if (wr_addr.size() != 2) begin n_bad++; $display("FAIL mid_writes_before: got %0d want 2", wr_addr.size()); end
    rx_if.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    wr_addr.delete();
    wr_data.delete();
    // 12^34^56^78 = 0x08
    img[0] = 32'h12345678;
    send_image(16'd1, 1, 8'h00, 1'b0);
    n_cmp++; if (wr_addr.size() != 1) begin n_bad++; $display("FAIL mid_fresh_count: got %0d want 1", wr_addr.size()); end
    if (wr_addr.size() == 1) begin
      n_cmp++; if (wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h12345678) begin n_bad++; $display("FAIL mid_fresh_write: got %0d:%h want 0:12345678", wr_addr[0], wr_data[0]); end
    end
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL mid_fresh_done: got %b want 1", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_csum();
    test_len_overflow();
    test_len_zero();
    test_full_depth();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
